// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: word width, reset defaults
// and FSM state encoding.
package instr_fetch_pkg;

    localparam int WORD_W = 20;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_PC_DEF = 20'h00000;
    localparam word_t PC_STEP_DEF  = 20'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory handshake and IF/ID output.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic  redirect_valid;
    word_t redirect_pc;
    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack;
    word_t imem_rdata;
    logic  if_valid;
    word_t if_pc;
    word_t if_instr;
    logic  id_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding-request instruction fetch stage with redirect/squash handling
// and a one-entry IF/ID output register.
//
// state | meaning
// IDLE  | one cycle after reset release, picks the first fetch address
// REQ   | imem_req high at addr_q, waiting for imem_ack
// HOLD  | fetched instruction presented on if_*, waiting for decode
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEF,
    parameter word_t PC_STEP  = PC_STEP_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        addr_q, addr_d;
    logic         squash_q, squash_d;
    logic         if_valid_q, if_valid_d;
    word_t        if_pc_q, if_pc_d;
    word_t        if_instr_q, if_instr_d;

    logic  xfer;
    word_t redir_or_pc;

    assign xfer        = if_valid_q && bus.id_ready;
    assign redir_or_pc = bus.redirect_valid ? bus.redirect_pc : pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            squash_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            squash_q   <= squash_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (bus.imem_ack && !squash_q && !bus.redirect_valid) state_d = ST_HOLD;
            ST_HOLD: if (xfer || bus.redirect_valid) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    // addr_q is separate from pc_q so a redirect can retarget pc while the
    // outstanding request keeps its address until its ack arrives.
    always_comb begin
        pc_d       = pc_q;
        addr_d     = addr_q;
        squash_d   = squash_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        unique case (state_q)
            ST_IDLE: begin
                pc_d   = redir_or_pc;
                addr_d = redir_or_pc;
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    if (squash_q || bus.redirect_valid) begin
                        pc_d     = redir_or_pc;
                        addr_d   = redir_or_pc;
                        squash_d = 1'b0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = addr_q;
                        if_instr_d = bus.imem_rdata;
                    end
                end else if (bus.redirect_valid) begin
                    pc_d     = bus.redirect_pc;
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (xfer) begin
                    if_valid_d = 1'b0;
                    pc_d       = bus.redirect_valid ? bus.redirect_pc : pc_q + PC_STEP;
                    addr_d     = bus.redirect_valid ? bus.redirect_pc : pc_q + PC_STEP;
                end else if (bus.redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = bus.redirect_pc;
                    addr_d     = bus.redirect_pc;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.imem_req  = (state_q == ST_REQ);
        bus.imem_addr = addr_q;
        bus.if_valid  = if_valid_q;
        bus.if_pc     = if_pc_q;
        bus.if_instr  = if_instr_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed redirect/reset scenarios plus random traffic,
// checked against a transaction-level model of the fetch rules.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC_DEF), .PC_STEP(PC_STEP_DEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: what the fetch stage should be doing in the current cycle
    bit    m_idle, m_hold, m_stale;
    word_t m_pc, m_req_addr, m_held_pc, m_held_instr;
    int    m_age, m_lat, lat_cfg;
    bit    cur_req, cur_hold;

    word_t         addr_q[$];
    logic [39:0]   exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic issue(input word_t a);
        m_req_addr = a;
        m_age      = 0;
        m_lat      = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        addr_q.push_back(a);
    endtask

    // Drive one cycle of inputs (called just after a rising edge) and advance the model.
    task automatic step(input bit redir, input word_t tgt, input bit rdy, input bit xack);
        bit    ack;
        word_t data;
        cur_req  = !m_idle && !m_hold;
        cur_hold = m_hold;
        data     = word_t'($urandom);
        ack      = m_idle ? xack : (cur_req && m_age == m_lat);
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        bus.id_ready       = rdy;
        bus.imem_ack       = ack;
        bus.imem_rdata     = data;
        if (m_idle) begin
            m_idle = 1'b0;
            if (redir) m_pc = tgt;
            issue(m_pc);
        end else if (m_hold) begin
            if (rdy) begin
                exp_q.push_back({m_held_pc, m_held_instr});
                m_hold = 1'b0;
                m_pc   = redir ? tgt : word_t'(m_pc + PC_STEP_DEF);
                issue(m_pc);
            end else if (redir) begin
                m_hold = 1'b0;
                m_pc   = tgt;
                issue(m_pc);
            end
        end else if (ack) begin
            if (m_stale || redir) begin
                m_stale = 1'b0;
                if (redir) m_pc = tgt;
                issue(m_pc);
            end else begin
                m_hold       = 1'b1;
                m_held_pc    = m_req_addr;
                m_held_instr = data;
            end
        end else begin
            m_age++;
            if (redir) begin
                m_pc    = tgt;
                m_stale = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.id_ready       = 1'b0;
        m_idle = 1'b1; m_hold = 1'b0; m_stale = 1'b0; m_pc = RESET_PC_DEF;
        cur_req = 1'b0; cur_hold = 1'b0;
        addr_q.delete();
        exp_q.delete();
        #1;
        chk("rst_imem_req",  bus.imem_req,  0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC_DEF);
        chk("rst_if_valid",  bus.if_valid,  0);
        chk("rst_if_pc",     bus.if_pc,     0);
        chk("rst_if_instr",  bus.if_instr,  0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_to_req(input word_t a);
        int n = 0;
        while (!(!m_idle && !m_hold && m_age == 0 && m_req_addr == a) && n < 60) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("reach_req", (!m_idle && !m_hold && m_req_addr == a), 1);
    endtask

    task automatic run_to_hold(input word_t a);
        int n = 0;
        while (!(m_hold && m_held_pc == a) && n < 60) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("reach_hold", (m_hold && m_held_pc == a), 1);
    endtask

    // monitor: request addresses, delivered instructions, timing and stability
    bit    prev_req, prev_ack, prev_valid, prev_ready;
    word_t prev_addr, prev_pc, prev_instr;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
        end else begin
            chk("if_valid_timing", bus.if_valid, cur_hold);
            chk("imem_req_timing", bus.imem_req, cur_req);
            if (bus.imem_req && (!prev_req || prev_ack)) begin
                chk("req_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) chk("imem_addr", bus.imem_addr, addr_q.pop_front());
            end else if (bus.imem_req && prev_req) begin
                chk("imem_addr_stable", bus.imem_addr, prev_addr);
            end
            if (bus.if_valid && bus.id_ready) begin
                chk("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    chk("if_pc",    bus.if_pc,    e[39:20]);
                    chk("if_instr", bus.if_instr, e[19:0]);
                end
            end
            if (bus.if_valid && prev_valid && !prev_ready) begin
                chk("hold_pc_stable",    bus.if_pc,    prev_pc);
                chk("hold_instr_stable", bus.if_instr, prev_instr);
            end
            prev_req   = bus.imem_req;
            prev_ack   = bus.imem_ack;
            prev_addr  = bus.imem_addr;
            prev_valid = bus.if_valid;
            prev_ready = bus.id_ready;
            prev_pc    = bus.if_pc;
            prev_instr = bus.if_instr;
        end
    end

    initial begin
        bit    redir, rdy;
        word_t tgt;

        // sequential fetch 0,4,8; redirect to 0x100 while 0x8 is outstanding; stall in HOLD
        lat_cfg = 2;
        do_reset();
        run_to_req(20'h00008);
        step(1'b1, 20'h00100, 1'b1, 1'b0);
        run_to_hold(20'h00100);
        repeat (5) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // redirect with same-cycle transfer, flush in HOLD, redirect coincident with ack
        lat_cfg = 1;
        do_reset();
        run_to_hold(20'h0000C);
        step(1'b1, 20'h00040, 1'b1, 1'b0);
        run_to_hold(20'h00040);
        step(1'b1, 20'h00200, 1'b0, 1'b0);
        run_to_hold(20'h00200);
        step(1'b0, '0, 1'b1, 1'b0);
        run_to_req(20'h00204);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 20'h00500, 1'b1, 1'b0);
        run_to_hold(20'h00500);
        step(1'b0, '0, 1'b1, 1'b0);

        // back-to-back redirects, last one to the top of the address space, then wrap
        lat_cfg = 3;
        run_to_req(20'h00504);
        step(1'b1, 20'h00123, 1'b1, 1'b0);
        step(1'b1, 20'hFFFFC, 1'b1, 1'b0);
        run_to_hold(20'hFFFFC);
        step(1'b0, '0, 1'b1, 1'b0);
        run_to_hold(20'h00000);
        step(1'b0, '0, 1'b1, 1'b0);

        // redirect during IDLE; reset mid-request with a late ack in IDLE
        do_reset();
        step(1'b1, 20'h00300, 1'b1, 1'b0);
        run_to_hold(20'h00300);
        step(1'b0, '0, 1'b1, 1'b0);
        lat_cfg = 2;
        run_to_req(20'h00304);
        step(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        step(1'b0, '0, 1'b1, 1'b1);
        run_to_hold(20'h00000);
        step(1'b0, '0, 1'b1, 1'b0);

        // random traffic
        lat_cfg = -1;
        repeat (3000) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            redir = ($urandom_range(0, 7) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? (20'hFFFF0 | word_t'($urandom & 32'hC))
                                                 : word_t'($urandom);
            rdy   = ($urandom_range(0, 9) < 7);
            step(redir, tgt, rdy, 1'b0);
        end

        cur_req  = !m_idle && !m_hold;
        cur_hold = m_hold;
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b0;
        @(negedge clk);
        #1;
        chk("addr_q_drained", addr_q.size(), 0);
        chk("exp_q_drained",  exp_q.size(),  0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
